// File: rtl/svm_pkg.sv
// Shared constants and the saturation helper for the linear-SVM MAC processing element.
// The fixed-point format is Q(FEA_I).(FEA_F), stored in words of W bits.
package svm_pkg;

    localparam int FEA_I  = 4;
    localparam int FEA_F  = 28;
    localparam int W      = FEA_I + FEA_F;
    localparam int BINS   = 9;
    localparam int PROD_W = 2 * W;
    localparam int DOT_W  = PROD_W + 4;
    localparam int ACC_W  = PROD_W + 6;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] x);
        logic signed [W-1:0] r;
        if (x > SAT_MAX)
            r = SAT_MAX[W-1:0];
        else if (x < SAT_MIN)
            r = SAT_MIN[W-1:0];
        else
            r = x[W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/svm_dot9.sv
// Nine-element signed dot product of one HOG cell against its SVM coefficients.
// Each product is 2W bits wide; the sum keeps full precision with 4 guard bits.
module svm_dot9
    import svm_pkg::*;
(
    input  logic [BINS*W-1:0]       fea_i,
    input  logic [BINS*W-1:0]       coef_i,
    output logic signed [DOT_W-1:0] sum_o
);

    logic signed [PROD_W-1:0] fx;
    logic signed [PROD_W-1:0] cx;
    logic signed [PROD_W-1:0] prod;
    logic signed [DOT_W-1:0]  acc;

    // Operands are widened to 2W first so the multiply is exact at full width.
    always_comb begin
        acc  = '0;
        fx   = '0;
        cx   = '0;
        prod = '0;
        for (int k = 0; k < BINS; k++) begin
            fx   = {{W{fea_i[k*W+W-1]}}, fea_i[k*W +: W]};
            cx   = {{W{coef_i[k*W+W-1]}}, coef_i[k*W +: W]};
            prod = fx * cx;
            acc  = acc + {{(DOT_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/svm_mac_pe.sv
// Systolic MAC element: four cell dot products plus the upstream partial sum,
// rescaled by floor shift, saturated to one word and registered for the next PE.
module svm_mac_pe
    import svm_pkg::*;
#(
    parameter int FEA_I = svm_pkg::FEA_I,
    parameter int FEA_F = svm_pkg::FEA_F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BINS*W-1:0]     fea_a,
    input  logic [BINS*W-1:0]     fea_b,
    input  logic [BINS*W-1:0]     fea_c,
    input  logic [BINS*W-1:0]     fea_d,
    input  logic [BINS*W-1:0]     coef_a,
    input  logic [BINS*W-1:0]     coef_b,
    input  logic [BINS*W-1:0]     coef_c,
    input  logic [BINS*W-1:0]     coef_d,
    input  logic [FEA_I+FEA_F-1:0] i_data,
    input  logic                  i_valid,
    output logic [FEA_I+FEA_F-1:0] o_data
);

    localparam int DW = FEA_I + FEA_F;

    logic signed [DOT_W-1:0] dot_a, dot_b, dot_c, dot_d;
    logic signed [ACC_W-1:0] sum_full;
    logic signed [ACC_W-1:0] sum_scaled;
    logic signed [ACC_W-1:0] total;
    logic signed [DW-1:0]    up_data;
    logic [DW-1:0]           o_data_d, o_data_q;

    svm_dot9 u_dot_a (.fea_i(fea_a), .coef_i(coef_a), .sum_o(dot_a));
    svm_dot9 u_dot_b (.fea_i(fea_b), .coef_i(coef_b), .sum_o(dot_b));
    svm_dot9 u_dot_c (.fea_i(fea_c), .coef_i(coef_c), .sum_o(dot_c));
    svm_dot9 u_dot_d (.fea_i(fea_d), .coef_i(coef_d), .sum_o(dot_d));

    // Arithmetic shift drops FEA_F fraction bits, rounding toward negative infinity.
    always_comb begin
        up_data    = i_data;
        sum_full   = ACC_W'(dot_a) + ACC_W'(dot_b) + ACC_W'(dot_c) + ACC_W'(dot_d);
        sum_scaled = sum_full >>> FEA_F;
        total      = sum_scaled + ACC_W'(up_data);
        o_data_d   = o_data_q;
        if (i_valid)
            o_data_d = sat_w(total);
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_data_q <= '0;
        else
            o_data_q <= o_data_d;
    end

    assign o_data = o_data_q;

endmodule

// File: tb/tb_svm_mac_pe.sv
// Directed-vector bench for svm_mac_pe with a queue-based scoreboard and monitor.
module tb_svm_mac_pe;

    localparam int W = 32;
    localparam int N = 9 * W;
    localparam logic [31:0] ONE  = 32'h1000_0000;
    localparam logic [31:0] HALF = 32'h0800_0000;
    localparam logic [31:0] NEG1 = 32'hF000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  fea_a, fea_b, fea_c, fea_d;
    logic [N-1:0]  coef_a, coef_b, coef_c, coef_d;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic [W-1:0]  o_data;

    logic [31:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    svm_mac_pe dut (
        .clk(clk), .rst(rst),
        .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
        .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
        .i_data(i_data), .i_valid(i_valid), .o_data(o_data)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation is pushed per clock edge; check it half a cycle later.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks = checks + 1;
            if (o_data !== e) begin
                failures = failures + 1;
                $display("FAIL o_data check#%0d got=%h exp=%h", checks, o_data, e);
            end
        end
    end

    task automatic clr_inputs();
        fea_a = '0; fea_b = '0; fea_c = '0; fea_d = '0;
        coef_a = '0; coef_b = '0; coef_c = '0; coef_d = '0;
        i_data = '0;
    endtask

    task automatic fill_all(input logic [31:0] f, input logic [31:0] c);
        for (int k = 0; k < 9; k++) begin
            fea_a[k*W +: W] = f; fea_b[k*W +: W] = f;
            fea_c[k*W +: W] = f; fea_d[k*W +: W] = f;
            coef_a[k*W +: W] = c; coef_b[k*W +: W] = c;
            coef_c[k*W +: W] = c; coef_d[k*W +: W] = c;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] exp_v);
        rst     = r;
        i_valid = v;
        @(posedge clk);
        exp_q.push_back(exp_v);
        @(negedge clk);
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        i_valid = 1'b0;

        step(1'b1, 1'b0, 32'h0000_0000);

        // Load a known value, then reset while i_valid is high.
        i_data = 32'h1234_5678;
        step(1'b0, 1'b1, 32'h1234_5678);
        step(1'b1, 1'b1, 32'h0000_0000);

        i_data = ONE;
        step(1'b0, 1'b1, ONE);

        clr_inputs();
        fea_a[0 +: W] = ONE; coef_a[0 +: W] = HALF;
        step(1'b0, 1'b1, HALF);

        // Hold with garbage inputs while i_valid is low.
        for (int i = 0; i < 5; i++) begin
            fill_all(ONE + i, NEG1);
            i_data = 32'hDEAD_0000 + i;
            step(1'b0, 1'b0, HALF);
        end

        clr_inputs();
        fea_d[8*W +: W] = NEG1; coef_d[8*W +: W] = HALF;
        step(1'b0, 1'b1, 32'hF800_0000);

        clr_inputs();
        fill_all(ONE, ONE);
        step(1'b0, 1'b1, 32'h7FFF_FFFF);

        fill_all(ONE, NEG1);
        step(1'b0, 1'b1, 32'h8000_0000);

        clr_inputs();
        fea_a[0 +: W] = 32'h0000_0001; coef_a[0 +: W] = HALF;
        step(1'b0, 1'b1, 32'h0000_0000);

        fea_a[0 +: W] = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 32'hFFFF_FFFF);

        // 1.0*0.5 + upstream 1.0 = 1.5
        clr_inputs();
        fea_a[0 +: W] = ONE; coef_a[0 +: W] = HALF; i_data = ONE;
        step(1'b0, 1'b1, 32'h1800_0000);

        // Upstream at max plus a positive product saturates.
        clr_inputs();
        fea_c[4*W +: W] = ONE; coef_c[4*W +: W] = ONE; i_data = 32'h7FFF_FFFF;
        step(1'b0, 1'b1, 32'h7FFF_FFFF);

        // 2.0*0.25 + (-0.5)*(-0.5) = 0.75
        clr_inputs();
        fea_b[3*W +: W] = 32'h2000_0000; coef_b[3*W +: W] = 32'h0400_0000;
        fea_c[5*W +: W] = 32'hF800_0000; coef_c[5*W +: W] = 32'hF800_0000;
        step(1'b0, 1'b1, 32'h0C00_0000);

        // Reset with i_valid low also clears.
        step(1'b1, 1'b0, 32'h0000_0000);

        // -1.0 + upstream 0.25 = -0.75
        clr_inputs();
        fea_b[0 +: W] = ONE; coef_b[0 +: W] = NEG1; i_data = 32'h0400_0000;
        step(1'b0, 1'b1, 32'hF400_0000);

        rst = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
